// File: rtl/uart_boot_pkg.sv
// rtl/uart_boot_pkg.sv - shared state encoding and framing constants for uart_boot_loader
// Optional feature macro: UART_BOOT_LOADER_CHECKSUM_EN adds the CHK state.
package uart_boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_BYTES         = 2;
  localparam int         WORD_BYTES        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERROR
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// rtl/boot_word_packer.sv - gathers four bytes little-endian into one 32-bit word
// word_valid pulses for one cycle after the strobe of each word's 4th byte.
module boot_word_packer
  import uart_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  count_q;
  logic [31:0] shreg_q;
  logic        valid_q;

  // Shifting in from the top leaves the first byte in [7:0] after four bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      shreg_q <= 32'd0;
      valid_q <= 1'b0;
    end else if (byte_valid_i) begin
      count_q <= count_q + 2'd1;
      shreg_q <= {byte_data_i, shreg_q[31:8]};
      valid_q <= (count_q == 2'(WORD_BYTES - 1));
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign word_valid = valid_q;
  assign word       = shreg_q;

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART frame parser that loads instruction memory then releases the core
// Define UART_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_e END_STATE = ST_CHK;
`else
  localparam boot_state_e END_STATE = ST_DONE;
`endif

  boot_state_e       state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              byte_valid;
  logic              word_valid;
  logic [31:0]       word;
  logic [15:0]       n_full;
  logic [16:0]       last_idx;
  logic              last_word;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  boot_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_valid_i (byte_valid),
    .byte_data_i  (rx_data),
    .word_valid   (word_valid),
    .word         (word)
  );

  assign n_full    = {rx_data, len_q[7:0]};
  assign last_idx  = {1'b0, len_q} - 17'd1;
  assign last_word = (last_idx == 17'(addr_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= 16'd0;
      addr_q  <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    byte_valid = 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN0;
      ST_LEN0: if (rx_valid) begin
        len_d[7:0] = rx_data;
        state_d    = ST_LEN1;
      end
      ST_LEN1: if (rx_valid) begin
        len_d[15:8] = rx_data;
        if (n_full == 16'd0)                state_d = END_STATE;
        else if ({1'b0, n_full} > MAX_WORDS) state_d = ST_ERROR;
        else                                 state_d = ST_DATA;
      end
      ST_DATA: begin
        byte_valid = rx_valid;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        if (rx_valid) csum_d = csum_q ^ rx_data;
`endif
        // The address only advances once its write pulse has been presented.
        if (word_valid) begin
          if (last_word) state_d = END_STATE;
          else           addr_d  = addr_q + 1'b1;
        end
      end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      ST_CHK: if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign imem_we    = word_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign cpu_reset  = (state_q != ST_DONE);
  assign boot_done  = (state_q == ST_DONE);
  assign boot_error = (state_q == ST_ERROR);

endmodule
